// File: rtl/ntt_bitrev_reorder.sv
// Ping-pong reorder buffer for an SDF NTT stage. Each frame of N coefficients arrives in
// bit-reversed order and is replayed in natural order. While one bank drains, the other
// bank fills, so the sustained rate is one word per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   upstream word present
//   in_ready   a word can be accepted (write bank not full)
//   in_data    coefficient, bit-reversed order within a frame
//   out_valid  read bank holds a complete frame
//   out_ready  downstream accepts the word
//   out_data   coefficient in natural order (0 when out_valid is low)
//   out_last   final word of a frame
module ntt_bitrev_reorder #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  localparam int unsigned L = $clog2(N);
  localparam logic [L-1:0] IdxMax = L'(N - 1);

  // Storage is deliberately not reset; the full flags gate all reads.
  logic [W-1:0] mem_q [2][N];

  logic [1:0]   full_q, full_d;
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [L-1:0] wr_idx_q, wr_idx_d;
  logic [L-1:0] rd_idx_q, rd_idx_d;

  logic wr_accept;
  logic rd_hs;

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] idx);
    logic [L-1:0] r;
    r = '0;
    for (int i = 0; i < int'(L); i++) begin
      r[i] = idx[L-1-i];
    end
    return r;
  endfunction

  // Handshake signals and outputs depend only on registered state.
  always_comb begin
    in_ready  = ~full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    wr_accept = in_valid && in_ready;
    rd_hs     = out_valid && out_ready;
    out_last  = out_valid && (rd_idx_q == IdxMax);
    out_data  = out_valid ? mem_q[rd_bank_q][rd_idx_q] : '0;
  end

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;

    if (wr_accept) begin
      wr_idx_d = wr_idx_q + L'(1);
      if (wr_idx_q == IdxMax) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // Set and clear always target different banks, so both may land in one cycle.
    if (rd_hs) begin
      rd_idx_d = rd_idx_q + L'(1);
      if (rd_idx_q == IdxMax) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_bank_q][bitrev(wr_idx_q)] <= in_data;
    end
  end

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
module tb_ntt_bitrev_reorder;

  localparam int W = 32;
  localparam int N = 8;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready, out_last;
  logic [W-1:0] in_data, out_data;

  // Extra builds: N = 16 and N = 2, streamed with out_ready held high.
  logic        v16, r16, ov16, ol16;
  logic [15:0] d16, od16;
  logic        v2, r2, ov2, ol2;
  logic [15:0] d2, od2;
  logic        one = 1'b1;

  always #5 clk = ~clk;

  ntt_bitrev_reorder #(.W(W), .N(N)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  ntt_bitrev_reorder #(.W(16), .N(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_data(d16),
    .out_valid(ov16), .out_ready(one), .out_data(od16), .out_last(ol16)
  );

  ntt_bitrev_reorder #(.W(16), .N(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .out_valid(ov2), .out_ready(one), .out_data(od2), .out_last(ol2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tb_bitrev(input int k, input int bits);
    int r = 0;
    int v = k;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] cur_q[$];
  int           full_cnt = 0;   // complete frames held in the buffer
  int           out_cnt = 0;
  int           pushed_cnt = 0;
  int           flushed_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  exp_t         e;

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_last", out_last, 0);
      flushed_cnt += exp_q.size();
      exp_q.delete();
      cur_q.delete();
      full_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, full_cnt < 2);
      check("out_valid", out_valid, full_cnt > 0);
      if (!out_valid) begin
        check("idle_out_data", out_data, 0);
        check("idle_out_last", out_last, 0);
      end
      if (prev_stall) check("stall_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          out_cnt++;
          if (e.last) full_cnt--;
        end
      end
      if (in_valid && in_ready) begin
        cur_q.push_back(in_data);
        if (cur_q.size() == N) begin
          for (int k = 0; k < N; k++) begin
            e.data = cur_q[tb_bitrev(k, L)];
            e.last = (k == N - 1);
            exp_q.push_back(e);
            pushed_cnt++;
          end
          cur_q.delete();
          full_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // out_ready policy: 0 hold, 1 always ready, 2 random
  int out_mode = 1;
  always @(posedge clk) begin
    #1;
    case (out_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [W-1:0] d, input int gap, output int stalls);
    logic acc;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    stalls   = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      stalls++;
      if (stalls > 300) begin
        check("send_timeout", stalls, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int stalls, tot_stalls;
  int exp16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int i16, i2;

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    v16 = 1'b0; d16 = '0; v2 = 1'b0; d2 = '0;
    #2;
    check("por_in_ready", in_ready, 1);
    check("por_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single frame 100..107
    out_mode = 1;
    for (int i = 0; i < N; i++) send(W'(100 + i), 0, stalls);
    wait_drain();

    // Two back-to-back frames, no stalls expected
    tot_stalls = 0;
    for (int i = 0; i < 2 * N; i++) begin
      send(W'(i), 0, stalls);
      tot_stalls += stalls;
    end
    check("b2b_no_stall", tot_stalls, 0);
    wait_drain();

    // Backpressure: two frames fill both banks, third frame waits
    out_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2 * N; i++) send(W'(1000 + i), 0, stalls);
    fork
      for (int i = 0; i < N; i++) send(W'(2000 + i), 0, stalls);
      begin
        repeat (5) @(posedge clk);
        #2;
        check("full_backpressure", in_ready, 0);
        out_mode = 1;
      end
    join
    wait_drain();

    // Random out_ready and input gaps
    out_mode = 2;
    for (int i = 0; i < 4 * N; i++) send(W'($urandom), $urandom_range(0, 2), stalls);
    out_mode = 1;
    wait_drain();

    // Reset while draining frame 0 and writing frame 1
    out_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N + 3; i++) send(W'(300 + i), 0, stalls);
    out_mode = 1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < N; i++) send(W'(200 + i), 0, stalls);
    wait_drain();

    check("no_loss", out_cnt, pushed_cnt - flushed_cnt);
    check("no_partial", cur_q.size(), 0);

    // N = 16 and N = 2 builds
    i16 = 0;
    i2  = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      v16 = (c < 16); d16 = 16'(c);
      v2  = (c < 2);  d2  = 16'(c);
      @(negedge clk);
      if (c < 16) check("n16_in_ready", r16, 1);
      if (ov16) begin
        check("n16_data", od16, (i16 < 16) ? exp16[i16] : 999);
        check("n16_last", ol16, i16 == 15);
        i16++;
      end
      if (ov2) begin
        check("n2_data", od2, i2);
        check("n2_last", ol2, i2 == 1);
        i2++;
      end
    end
    check("n16_count", i16, 16);
    check("n2_count", i2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
